// File: rtl/ram_bus_ctrl.sv
// Sequencer from the CPU's single-request memory port to an asynchronous
// strobe-style static RAM. It handles WE_N timing, byte-lane steering and error flagging.
module ram_bus_ctrl #(
  parameter int RAM_BYTES = 16384,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 1,
  parameter int RD_CYC    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] ram_a,
  output logic [15:0] ram_di,
  input  logic [15:0] ram_do,
  output logic        ram_ce_n,
  output logic        ram_we_n,
  output logic        ram_byte_op
);

  localparam int MAX_AB = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
  localparam int MAXC   = (MAX_AB > RD_CYC) ? MAX_AB : RD_CYC;
  localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [16:0] RAM_LIM = 17'(RAM_BYTES);

  // One-hot so that the RAM strobe decodes come from flop outputs with minimal logic.
  typedef enum logic [5:0] {
    IDLE    = 6'b000001,
    SETUP   = 6'b000010,
    WSTROBE = 6'b000100,
    RECOVER = 6'b001000,
    READ    = 6'b010000,
    DONE    = 6'b100000
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_load;
  logic          cnt_zero;
  logic          we_q, err_q;
  logic          accept, bad_req;
  logic [15:0]   di_steer;

  assign cnt_zero = (cnt == '0);
  assign accept   = (state == IDLE) && req;
  assign bad_req  = (!byte_op && addr[0]) || ({1'b0, addr} >= RAM_LIM);
  assign di_steer = byte_op ? {8'h00, (addr[0] ? wdata[15:8] : wdata[7:0])} : wdata;

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = bad_req ? DONE : SETUP;
      SETUP:   if (cnt_zero) nxt = we_q ? WSTROBE : READ;
      WSTROBE: if (cnt_zero) nxt = RECOVER;
      RECOVER: nxt = DONE;
      READ:    if (cnt_zero) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    busy     = (state != IDLE);
    ack      = (state == DONE);
    err      = (state == DONE) && err_q;
    ram_ce_n = !((state == SETUP) || (state == WSTROBE) ||
                 (state == RECOVER) || (state == READ));
    ram_we_n = !(state == WSTROBE);
  end

  // Each timed state is entered with its length minus one and leaves when the count reaches zero.
  always_comb begin
    cnt_load = '0;
    case (nxt)
      SETUP:   cnt_load = CW'(SETUP_CYC - 1);
      WSTROBE: cnt_load = CW'(WE_CYC - 1);
      READ:    cnt_load = CW'(RD_CYC - 1);
      default: cnt_load = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)              cnt <= '0;
    else if (nxt != state)  cnt <= cnt_load;
    else if (!cnt_zero)     cnt <= cnt - 1'b1;
  end

  // Address, data and mode change only at acceptance, so they are stable around every WE_N edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_a       <= '0;
      ram_di      <= '0;
      ram_byte_op <= 1'b0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
    end else if (accept) begin
      ram_a       <= addr;
      ram_di      <= di_steer;
      ram_byte_op <= byte_op;
      we_q        <= we;
      err_q       <= bad_req;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                          rdata <= '0;
    else if ((state == READ) && cnt_zero) rdata <= ram_do;
  end

endmodule
